// File: rtl/bf_mul_if.sv
// Operand/result handshake bundle for the pipelined floating-point multiplier.
// A transfer happens on a rising edge where valid & ready are both 1; valid and payload stay put until then.
interface bf_mul_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int ERROR_WIDTH = 2
);
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_WIDTH-1:0]  in1;
    logic [DATA_WIDTH-1:0]  in2;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_WIDTH-1:0]  out;
    logic [ERROR_WIDTH-1:0] error;

    modport master (
        output in_valid, in1, in2, out_ready,
        input  in_ready, out_valid, out, error
    );

    modport slave (
        input  in_valid, in1, in2, out_ready,
        output in_ready, out_valid, out, error
    );
endinterface

// File: rtl/bf_mul_pipe.sv
// 3-stage pipelined floating-point multiplier (decode/multiply, normalise/round, resolve/output).
// Define BF_MUL_ROUND_EN for round-to-nearest-even; otherwise dropped product bits are truncated.
module bf_mul_pipe #(
    parameter int EXP_WIDTH   = 8,
    parameter int FRAC_WIDTH  = 7,
    parameter int DATA_WIDTH  = 1 + EXP_WIDTH + FRAC_WIDTH,
    parameter int ERROR_WIDTH = 2
) (
    input logic   clk,
    input logic   rst_n,
    bf_mul_if.slave bus
);
    localparam int MW = FRAC_WIDTH + 1;
    localparam int PW = 2 * MW;
    localparam int SW = EXP_WIDTH + 2;

    localparam logic signed [SW-1:0] BIAS     = SW'((1 << (EXP_WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] EXP_MAX  = SW'((1 << EXP_WIDTH) - 1);
    localparam logic signed [SW-1:0] EXP_ZERO = '0;

    localparam logic [ERROR_WIDTH-1:0] ERR_OK  = ERROR_WIDTH'(0);
    localparam logic [ERROR_WIDTH-1:0] ERR_OVF = ERROR_WIDTH'(1);
    localparam logic [ERROR_WIDTH-1:0] ERR_UNF = ERROR_WIDTH'(2);
    localparam logic [ERROR_WIDTH-1:0] ERR_NAN = ERROR_WIDTH'(3);

    localparam logic [DATA_WIDTH-1:0] QNAN =
        {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(FRAC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {K_NUM, K_ZERO, K_INF, K_NAN} kind_t;

    // Every stage moves together whenever the output register is free or being drained.
    logic advance;
    assign advance      = bus.out_ready | ~bus.out_valid;
    assign bus.in_ready = advance;

    // ---------------- S1: decode, classify, exponent sum, mantissa product
    logic                 sign_a, sign_b;
    logic [EXP_WIDTH-1:0] exp_a, exp_b;
    logic [FRAC_WIDTH-1:0] frac_a, frac_b;
    logic a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
    kind_t                kind_in;
    logic signed [SW-1:0] exp_sum;
    logic [PW-1:0]        prod;

    assign sign_a = bus.in1[DATA_WIDTH-1];
    assign sign_b = bus.in2[DATA_WIDTH-1];
    assign exp_a  = bus.in1[DATA_WIDTH-2 -: EXP_WIDTH];
    assign exp_b  = bus.in2[DATA_WIDTH-2 -: EXP_WIDTH];
    assign frac_a = bus.in1[FRAC_WIDTH-1:0];
    assign frac_b = bus.in2[FRAC_WIDTH-1:0];

    // Exponent 0 covers subnormals too; they flush to zero.
    assign a_nan  = (&exp_a) & (|frac_a);
    assign a_inf  = (&exp_a) & ~(|frac_a);
    assign a_zero = ~(|exp_a);
    assign b_nan  = (&exp_b) & (|frac_b);
    assign b_inf  = (&exp_b) & ~(|frac_b);
    assign b_zero = ~(|exp_b);

    always_comb begin
        kind_in = K_NUM;
        if (a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf)) kind_in = K_NAN;
        else if (a_inf | b_inf)                                  kind_in = K_INF;
        else if (a_zero | b_zero)                                kind_in = K_ZERO;
    end

    assign exp_sum = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS;
    assign prod    = {1'b1, frac_a} * {1'b1, frac_b};

    logic                 v1, sign1;
    kind_t                kind1;
    logic signed [SW-1:0] exp1;
    logic [PW-1:0]        prod1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            sign1 <= 1'b0;
            kind1 <= K_ZERO;
            exp1  <= '0;
            prod1 <= '0;
        end else if (advance) begin
            v1    <= bus.in_valid;
            sign1 <= sign_a ^ sign_b;
            kind1 <= kind_in;
            exp1  <= exp_sum;
            prod1 <= prod;
        end
    end

    // ---------------- S2: normalise so the leading one sits at PW-1, then round
    logic                  norm, carry;
    logic [PW-1:0]         shifted;
    logic [FRAC_WIDTH-1:0] frac_t, frac_r;
    logic [FRAC_WIDTH:0]   dropped;
    logic signed [SW-1:0]  exp_n;

    assign norm    = prod1[PW-1];
    assign shifted = norm ? prod1 : (prod1 << 1);
    assign frac_t  = shifted[PW-2 -: FRAC_WIDTH];
    assign dropped = shifted[PW-2-FRAC_WIDTH:0];

`ifdef BF_MUL_ROUND_EN
    logic                round_up;
    logic [FRAC_WIDTH:0] frac_sum;
    // Guard bit plus sticky; an exact tie only rounds up when the kept LSB is odd.
    assign round_up = dropped[FRAC_WIDTH] & ((|dropped[FRAC_WIDTH-1:0]) | frac_t[0]);
    assign frac_sum = {1'b0, frac_t} + {{FRAC_WIDTH{1'b0}}, round_up};
    // All-ones fraction wraps to 1.000..., the carry bumps the exponent.
    assign carry    = frac_sum[FRAC_WIDTH];
    assign frac_r   = frac_sum[FRAC_WIDTH-1:0];
`else
    logic unused_dropped;
    assign unused_dropped = |dropped;
    assign carry          = 1'b0;
    assign frac_r         = frac_t;
`endif

    assign exp_n = exp1 + $signed({{(SW-1){1'b0}}, norm}) + $signed({{(SW-1){1'b0}}, carry});

    logic                  v2, sign2;
    kind_t                 kind2;
    logic signed [SW-1:0]  exp2;
    logic [FRAC_WIDTH-1:0] frac2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            sign2 <= 1'b0;
            kind2 <= K_ZERO;
            exp2  <= '0;
            frac2 <= '0;
        end else if (advance) begin
            v2    <= v1;
            sign2 <= sign1;
            kind2 <= kind1;
            exp2  <= exp_n;
            frac2 <= frac_r;
        end
    end

    // ---------------- S3: range check, special-value mux, output register
    logic [DATA_WIDTH-1:0]  res;
    logic [ERROR_WIDTH-1:0] err;

    always_comb begin
        res = '0;
        err = ERR_OK;
        unique case (kind2)
            K_NAN: begin
                res = QNAN;
                err = ERR_NAN;
            end
            K_INF:  res = {sign2, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
            K_ZERO: res = {sign2, {(DATA_WIDTH-1){1'b0}}};
            default: begin
                if (exp2 >= EXP_MAX) begin
                    res = {sign2, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
                    err = ERR_OVF;
                end else if (exp2 <= EXP_ZERO) begin
                    res = {sign2, {(DATA_WIDTH-1){1'b0}}};
                    err = ERR_UNF;
                end else begin
                    res = {sign2, exp2[EXP_WIDTH-1:0], frac2};
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out       <= '0;
            bus.error     <= ERR_OK;
        end else if (advance) begin
            bus.out_valid <= v2;
            if (v2) begin
                bus.out   <= res;
                bus.error <= err;
            end
        end
    end
endmodule

// File: tb/tb_bf_mul_pipe.sv
// Directed self-checking bench for bf_mul_pipe (bfloat16 defaults).
module tb_bf_mul_pipe;
  localparam int NV = 14;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bf_mul_if #(.DATA_WIDTH(16), .ERROR_WIDTH(2)) bus ();

  bf_mul_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [17:0] exp_q[$];

  localparam logic [15:0] RND_EXP   =
`ifdef BF_MUL_ROUND_EN
    16'h4012;
`else
    16'h4011;
`endif
  localparam logic [15:0] CARRY_EXP =
`ifdef BF_MUL_ROUND_EN
    16'h4000;
`else
    16'h3FFF;
`endif

  logic [15:0] va [NV] = '{16'h3F80, 16'h3FC0, 16'h3FC1, 16'h3F81, 16'h7F00, 16'h0080, 16'h8080,
                           16'h7F80, 16'hFFC1, 16'hFF80, 16'hC000, 16'h0000, 16'h8000, 16'h3FB5};
  logic [15:0] vb [NV] = '{16'h4000, 16'h3FC0, 16'h3FC1, 16'h3F81, 16'h7F00, 16'h0080, 16'h0080,
                           16'h0000, 16'h3F80, 16'h4000, 16'h4000, 16'h4000, 16'h3F80, 16'h3FB5};
  logic [15:0] vo [NV] = '{16'h4000, 16'h4010, RND_EXP,  16'h3F82, 16'h7F80, 16'h0000, 16'h8000,
                           16'h7FC0, 16'h7FC0, 16'hFF80, 16'hC080, 16'h0000, 16'h8000, CARRY_EXP};
  logic [1:0]  ve [NV] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b10,
                           2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};

  // Accept one vector into an idle pipeline and measure edges until out_valid.
  task automatic run_one(input int i, input string tag);
    int lat;
    @(negedge clk);
    bus.in1       = va[i];
    bus.in2       = vb[i];
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s[%0d] in_ready: got %b want 1", tag, i, bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 3) begin
      failures++;
      $display("FAIL %s[%0d] latency: got %0d want 3", tag, i, lat);
    end
    checks++;
    if (bus.out !== vo[i]) begin
      failures++;
      $display("FAIL %s[%0d] out (%h*%h): got %h want %h", tag, i, va[i], vb[i], bus.out, vo[i]);
    end
    checks++;
    if (bus.error !== ve[i]) begin
      failures++;
      $display("FAIL %s[%0d] error: got %b want %b", tag, i, bus.error, ve[i]);
    end
  endtask

  task automatic test_reset;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in1       = '0;
    bus.in2       = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset out_valid: got %b want 0", bus.out_valid);
    end
    checks++;
    if (bus.out !== 16'h0000) begin
      failures++;
      $display("FAIL reset out: got %h want 0000", bus.out);
    end
    checks++;
    if (bus.error !== 2'b00) begin
      failures++;
      $display("FAIL reset error: got %b want 00", bus.error);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_directed;
    for (int i = 0; i < NV; i++) run_one(i, "directed");
  endtask

  task automatic test_back_to_back;
    int sent = 0;
    int recv = 0;
    int cyc  = 0;
    logic stalled = 1'b0;
    logic [15:0] held_out;
    logic [1:0]  held_err;
    logic [17:0] exp_v;
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    exp_q.delete();
    while ((sent < 8 || recv < 8) && cyc < 200) begin
      @(negedge clk);
      if (stalled) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out !== held_out || bus.error !== held_err) begin
          failures++;
          $display("FAIL b2b stall hold: got v=%b %h/%b want v=1 %h/%b",
                   bus.out_valid, bus.out, bus.error, held_out, held_err);
        end
      end
      bus.out_ready = pat[cyc % 4];
      bus.in_valid  = (sent < 8);
      if (sent < 8) begin
        bus.in1 = va[sent];
        bus.in2 = vb[sent];
      end
      #1;
      checks++;
      if (bus.in_ready !== (bus.out_ready | ~bus.out_valid)) begin
        failures++;
        $display("FAIL b2b in_ready: got %b want %b", bus.in_ready, bus.out_ready | ~bus.out_valid);
      end
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL b2b extra output: got %h want none", bus.out);
        end else begin
          exp_v = exp_q.pop_front();
          if ({bus.error, bus.out} !== exp_v) begin
            failures++;
            $display("FAIL b2b result %0d: got %b/%h want %b/%h",
                     recv, bus.error, bus.out, exp_v[17:16], exp_v[15:0]);
          end
        end
        recv++;
      end
      if (bus.in_valid && bus.in_ready === 1'b1) begin
        exp_q.push_back({ve[sent], vo[sent]});
        sent++;
      end
      stalled  = (bus.out_valid === 1'b1) && !bus.out_ready;
      held_out = bus.out;
      held_err = bus.error;
      cyc++;
    end
    checks++;
    if (recv != 8 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b count: got %0d results (%0d pending) want 8 (0)", recv, exp_q.size());
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_midflight;
    @(negedge clk);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in1      = va[i + 3];
      bus.in2      = vb[i + 3];
      bus.in_valid = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL midreset pre out_valid: got %b want 1", bus.out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out !== 16'h0000 || bus.error !== 2'b00) begin
      failures++;
      $display("FAIL midreset clear: got v=%b %h/%b want v=0 0000/00",
               bus.out_valid, bus.out, bus.error);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL midreset ghost cycle %0d: got out_valid %b want 0", c, bus.out_valid);
      end
    end
    run_one(1, "post_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/bf_mul_pipe.md
Name: bf_mul_pipe

Overview:
- Parametrised, pipelined floating-point multiplier. Next generation of the combinational bfloat16 multiplier.
- Generic exponent and fraction widths; 3-stage registered datapath with valid/ready handshake.
- Round-to-nearest-even is optional; canonical special-value handling and a 2-bit error code.
- Sits between operand FIFOs and the accumulator in the MAC datapath.

Parameters:
- EXP_WIDTH, 8, exponent field width (bias = 2^(EXP_WIDTH-1)-1).
- FRAC_WIDTH, 7, stored fraction width (hidden bit implied).
- DATA_WIDTH, 1+EXP_WIDTH+FRAC_WIDTH, operand/result width (derived; do not override).
- ERROR_WIDTH, 2, error code width.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block accepts operands this cycle.
- in1  input  DATA_WIDTH  operand A.
- in2  input  DATA_WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out  output  DATA_WIDTH  product.
- error  output  ERROR_WIDTH  00 ok, 01 overflow, 10 underflow, 11 NaN.

Behaviour:
- Reset (async assert, sync release): all stage valid bits 0; out_valid=0, out=0, error=0. in_ready is 1 after reset.
- Pipeline:
  - S1: decode, classify (NaN/inf/zero), sign XOR, exponent sum, mantissa product.
  - S2: normalise, round.
  - S3: exponent adjust, overflow/underflow check, special-case mux, output register.
  - Latency is exactly 3 cycles from accept to out_valid with out_ready held 1. Throughput is 1 per cycle.
- Handshake:
  - advance = out_ready | ~out_valid. in_ready = advance.
  - Transfer in occurs when in_valid & in_ready; transfer out occurs when out_valid & out_ready.
  - While advance=0, all stages hold: registers and out/error stable, no data lost or duplicated.
  - On advance, every stage shifts. Bubbles (valid=0) propagate; they are not collapsed.
  - Simultaneous in and out transfer in the same cycle is legal.
- Classification:
  - Exponent all ones with frac≠0 is NaN; with frac=0 it is inf.
  - Exponent 0 is zero. Subnormals flush to zero; sign is kept for the zero product.
- Special results, priority order:
  - NaN input or inf×0: out = {0, all ones, 1, 0...} (canonical quiet NaN, sign 0), error 11.
  - inf×finite-nonzero or inf×inf: ±inf, error 00.
  - zero×finite: ±0, error 00.
- Arithmetic:
  - Exponent is computed signed in EXP_WIDTH+2 bits: e = e1 + e2 - bias + norm + round_carry.
  - Mantissa product is 2·(FRAC_WIDTH+1) bits. norm = product MSB.
  - Rounding carry-out (mantissa all ones rounds up) increments the exponent and renormalises to 1.000…
  - e ≥ all-ones: overflow → ±inf, error 01.
  - e ≤ 0: underflow → ±0, error 10. No subnormal output.
- Reset mid-operation clears all in-flight results; nothing is emitted for them.

Optional Feature:
- Macro BF_MUL_ROUND_EN.
- Defined: round-to-nearest-even using guard bit plus sticky OR of the remaining product bits. A tie rounds to even LSB.
- Undefined: truncate the dropped bits; no rounding carry path.
- Latency and handshake are identical in both builds.

Test Plan:
- 0x3F80×0x4000 (1.0×2.0), out_ready=1 → out=0x4000, error=00, out_valid exactly 3 cycles after accept. 0x3FC0×0x3FC0 → 0x4010.
- 0x3FC1×0x3FC1 → 0x4012 with BF_MUL_ROUND_EN, 0x4011 without. 0x3F81×0x3F81 → 0x3F82 in both builds.
- 0x7F00×0x7F00 → 0x7F80, error=01. 0x0080×0x0080 → 0x0000, error=10. 0x8080×0x0080 → 0x8000, error=10.
- 0x7F80×0x0000 → 0x7FC0, error=11. 0xFFC1×0x3F80 → 0x7FC0, error=11. 0xFF80×0x4000 → 0xFF80, error=00.
- Stream 8 back-to-back products with out_ready toggled 1,0,0,1,… → outputs in order, none dropped or duplicated, out stable while stalled, in_ready mirrors advance.
- Assert rst_n low with 3 results in flight → out_valid=0, out=0, error=0 immediately. After release, the first new result appears 3 cycles after accept.
